// File: rtl/debug_pkg.sv
// Shared constants and types for the debug module register/command engine.
package debug_pkg;

  localparam logic [6:0] ADDR_DATA0      = 7'h04;
  localparam logic [6:0] ADDR_DATA1      = 7'h05;
  localparam logic [6:0] ADDR_DMCONTROL  = 7'h10;
  localparam logic [6:0] ADDR_DMSTATUS   = 7'h11;
  localparam logic [6:0] ADDR_ABSTRACTCS = 7'h16;
  localparam logic [6:0] ADDR_COMMAND    = 7'h17;

  typedef enum logic [2:0] {
    CMDERR_NONE       = 3'd0,
    CMDERR_BUSY       = 3'd1,
    CMDERR_NOTSUP     = 3'd2,
    CMDERR_EXCEPTION  = 3'd3,
    CMDERR_HALTRESUME = 3'd4,
    CMDERR_BUS        = 3'd5
  } cmderr_e;

  localparam logic [7:0] CMDTYPE_ACCESS_REG = 8'd0;
  localparam logic [7:0] CMDTYPE_ACCESS_MEM = 8'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } cmd_state_e;

  localparam int DMCONTROL_HALTREQ     = 31;
  localparam int DMCONTROL_RESUMEREQ   = 30;
  localparam int DMCONTROL_DMACTIVE    = 0;
  localparam int ABSTRACTCS_BUSY       = 12;
  localparam int ABSTRACTCS_CMDERR_LSB = 8;

  function automatic logic cmdtype_supported(input logic [7:0] cmdtype);
    return (cmdtype == CMDTYPE_ACCESS_REG) || (cmdtype == CMDTYPE_ACCESS_MEM);
  endfunction

endpackage

// File: rtl/debug_if.sv
// Core-side debug interface: requests toward the core, completion back from it.
interface debug_if;
  logic        halt_req;
  logic        resume_req;
  logic        exec;
  logic [31:0] command;
  logic [31:0] data0_in;
  logic [31:0] data1_in;
  logic        halted;
  logic        done;
  logic        write;
  logic        bus;
  logic        haltresume;
  logic        exception;
  logic [31:0] data0_out;

  modport master (
    output halt_req, resume_req, exec, command, data0_in, data1_in,
    input  halted, done, write, bus, haltresume, exception, data0_out
  );

  modport slave (
    input  halt_req, resume_req, exec, command, data0_in, data1_in,
    output halted, done, write, bus, haltresume, exception, data0_out
  );
endinterface

// File: rtl/debug_dm_ctrl.sv
// Debug Module register file and abstract-command engine: DMI slave, core-side master.
// state   | meaning
// ST_IDLE | no abstract command outstanding
// ST_EXEC | command handed to core, exec held until a non-resume done
module debug_dm_ctrl
  import debug_pkg::*;
#(
  parameter int unsigned DATACOUNT  = 2,
  parameter int unsigned DM_VERSION = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dmi_req,
  input  logic        dmi_we,
  input  logic [6:0]  dmi_addr,
  input  logic [31:0] dmi_wdata,
  output logic [31:0] dmi_rdata,
  output logic        dmi_ack,
  debug_if.master     dbg
);

  cmd_state_e  state_q, state_d;
  cmderr_e     cmderr_q, cmderr_d;
  logic        dmactive_q, dmactive_d;
  logic        haltreq_q, haltreq_d;
  logic        resume_req_q, resume_req_d;
  logic        resumeack_q, resumeack_d;
  logic [31:0] command_q, command_d;
  logic [31:0] data0_q, data0_d;
  logic [31:0] data1_q, data1_d;
  logic [31:0] dmi_rdata_q, dmi_rdata_d;
  logic        dmi_ack_q, dmi_ack_d;
  logic        busy;
  logic [31:0] rd_mux;

  assign busy = (state_q == ST_EXEC);

  always_comb begin
    rd_mux = '0;
    case (dmi_addr)
      ADDR_DATA0:     rd_mux = data0_q;
      ADDR_DATA1:     rd_mux = data1_q;
      ADDR_COMMAND:   rd_mux = command_q;
      ADDR_DMCONTROL: begin
        rd_mux[DMCONTROL_HALTREQ]  = haltreq_q;
        rd_mux[DMCONTROL_DMACTIVE] = dmactive_q;
      end
      ADDR_DMSTATUS: begin
        rd_mux[3:0]   = 4'(DM_VERSION);
        rd_mux[7]     = 1'b1;
        rd_mux[9:8]   = {2{dbg.halted}};
        rd_mux[11:10] = {2{~dbg.halted}};
        rd_mux[17:16] = {2{resumeack_q}};
      end
      ADDR_ABSTRACTCS: begin
        rd_mux[ABSTRACTCS_BUSY]                = busy;
        rd_mux[ABSTRACTCS_CMDERR_LSB +: 3]     = cmderr_q;
        rd_mux[3:0]                            = 4'(DATACOUNT);
      end
      default: rd_mux = '0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cmderr_d     = cmderr_q;
    dmactive_d   = dmactive_q;
    haltreq_d    = haltreq_q;
    resume_req_d = resume_req_q;
    resumeack_d  = resumeack_q;
    command_d    = command_q;
    data0_d      = data0_q;
    data1_d      = data1_q;
    dmi_ack_d    = dmi_req;
    dmi_rdata_d  = (dmi_req && !dmi_we) ? rd_mux : '0;

    if (dmi_req && dmi_we && dmi_addr == ADDR_DMCONTROL) begin
      dmactive_d = dmi_wdata[DMCONTROL_DMACTIVE];
      haltreq_d  = dmi_wdata[DMCONTROL_HALTREQ];
      if (dmi_wdata[DMCONTROL_RESUMEREQ] && !dmi_wdata[DMCONTROL_HALTREQ] && dbg.halted) begin
        resume_req_d = 1'b1;
        resumeack_d  = 1'b0;
      end
    end else if (dmi_req && dmi_we && dmactive_q) begin
      case (dmi_addr)
        ADDR_DATA0: begin
          if (busy) begin
            if (cmderr_q == CMDERR_NONE) cmderr_d = CMDERR_BUSY;
          end else data0_d = dmi_wdata;
        end
        ADDR_DATA1: begin
          if (busy) begin
            if (cmderr_q == CMDERR_NONE) cmderr_d = CMDERR_BUSY;
          end else data1_d = dmi_wdata;
        end
        ADDR_ABSTRACTCS:
          cmderr_d = cmderr_e'(cmderr_q & ~dmi_wdata[ABSTRACTCS_CMDERR_LSB +: 3]);
        ADDR_COMMAND: begin
          if (busy) begin
            if (cmderr_q == CMDERR_NONE) cmderr_d = CMDERR_BUSY;
          end else begin
            command_d = dmi_wdata;
            if (cmderr_q != CMDERR_NONE) begin
              // a pending error blocks new commands until software clears it
            end else if (!cmdtype_supported(dmi_wdata[31:24])) cmderr_d = CMDERR_NOTSUP;
            else if (!dbg.halted) cmderr_d = CMDERR_HALTRESUME;
            else state_d = ST_EXEC;
          end
        end
        default: ;
      endcase
    end

    if (dbg.done) begin
      if (dbg.haltresume) begin
        resume_req_d = 1'b0;
        resumeack_d  = 1'b1;
      end else if (state_q == ST_EXEC) begin
        state_d = ST_IDLE;
        if (dbg.exception) cmderr_d = dbg.bus ? CMDERR_BUS : CMDERR_EXCEPTION;
        else if (dbg.write) data0_d = dbg.data0_out;
      end
    end

    // an inactive DM holds everything but dmactive at reset, including an in-flight command
    if (!dmactive_d) begin
      state_d      = ST_IDLE;
      cmderr_d     = CMDERR_NONE;
      haltreq_d    = 1'b0;
      resume_req_d = 1'b0;
      resumeack_d  = 1'b0;
      command_d    = '0;
      data0_d      = '0;
      data1_d      = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cmderr_q     <= CMDERR_NONE;
      dmactive_q   <= 1'b0;
      haltreq_q    <= 1'b0;
      resume_req_q <= 1'b0;
      resumeack_q  <= 1'b0;
      command_q    <= '0;
      data0_q      <= '0;
      data1_q      <= '0;
      dmi_rdata_q  <= '0;
      dmi_ack_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmderr_q     <= cmderr_d;
      dmactive_q   <= dmactive_d;
      haltreq_q    <= haltreq_d;
      resume_req_q <= resume_req_d;
      resumeack_q  <= resumeack_d;
      command_q    <= command_d;
      data0_q      <= data0_d;
      data1_q      <= data1_d;
      dmi_rdata_q  <= dmi_rdata_d;
      dmi_ack_q    <= dmi_ack_d;
    end
  end

  assign dmi_rdata      = dmi_rdata_q;
  assign dmi_ack        = dmi_ack_q;
  assign dbg.halt_req   = haltreq_q;
  assign dbg.resume_req = resume_req_q;
  assign dbg.exec       = busy;
  assign dbg.command    = command_q;
  assign dbg.data0_in   = data0_q;
  assign dbg.data1_in   = data1_q;

endmodule

// File: tb/tb_debug_dm_ctrl.sv
// Bench for debug_dm_ctrl: directed scenarios plus random DMI/core traffic against a transaction model.
module tb_debug_dm_ctrl;
  import debug_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dmi_req, dmi_we;
  logic [6:0]  dmi_addr;
  logic [31:0] dmi_wdata, dmi_rdata;
  logic        dmi_ack;

  debug_if dbg ();

  debug_dm_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .dmi_req   (dmi_req),
    .dmi_we    (dmi_we),
    .dmi_addr  (dmi_addr),
    .dmi_wdata (dmi_wdata),
    .dmi_rdata (dmi_rdata),
    .dmi_ack   (dmi_ack),
    .dbg       (dbg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // transaction-level model of the DM's architectural state
  bit          m_active, m_haltreq, m_resume, m_rack, m_busy, m_halted;
  logic [2:0]  m_cmderr;
  logic [31:0] m_cmd, m_d0, m_d1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_active = 0; m_haltreq = 0; m_resume = 0; m_rack = 0; m_busy = 0;
    m_cmderr = 0; m_cmd = 0; m_d0 = 0; m_d1 = 0;
  endfunction

  function automatic logic [31:0] model_read(input logic [6:0] a);
    case (a)
      7'h04: return m_d0;
      7'h05: return m_d1;
      7'h17: return m_cmd;
      7'h10: return {m_haltreq, 30'b0, m_active};
      7'h11: return {14'b0, m_rack, m_rack, 4'b0, !m_halted, !m_halted, m_halted, m_halted,
                     1'b1, 3'b0, 4'd2};
      7'h16: return {19'b0, m_busy, 1'b0, m_cmderr, 4'b0, 4'd2};
      default: return 32'h0;
    endcase
  endfunction

  function automatic void model_write(input logic [6:0] a, input logic [31:0] wd);
    if (a == 7'h10) begin
      m_active = wd[0];
      if (!m_active) begin model_reset(); return; end
      m_haltreq = wd[31];
      if (wd[30] && !wd[31] && m_halted) begin m_resume = 1; m_rack = 0; end
      return;
    end
    if (!m_active) return;
    case (a)
      7'h04, 7'h05: begin
        if (m_busy) begin if (m_cmderr == 0) m_cmderr = 1; end
        else if (a == 7'h04) m_d0 = wd;
        else m_d1 = wd;
      end
      7'h16: m_cmderr = m_cmderr & ~wd[10:8];
      7'h17: begin
        if (m_busy) begin if (m_cmderr == 0) m_cmderr = 1; end
        else begin
          m_cmd = wd;
          if (m_cmderr != 0) ;
          else if (wd[31:24] != 8'd0 && wd[31:24] != 8'd2) m_cmderr = 2;
          else if (!m_halted) m_cmderr = 4;
          else m_busy = 1;
        end
      end
      default: ;
    endcase
  endfunction

  function automatic void model_done(input bit w, input bit b, input bit hr, input bit e,
                                     input logic [31:0] d);
    if (!m_active) return;
    if (hr) begin m_resume = 0; m_rack = 1; end
    else if (m_busy) begin
      m_busy = 0;
      if (e) m_cmderr = b ? 3'd5 : 3'd3;
      else if (w) m_d0 = d;
    end
  endfunction

  task automatic check_outputs();
    check_val("halt_req",   32'(dbg.halt_req),   32'(m_haltreq));
    check_val("resume_req", 32'(dbg.resume_req), 32'(m_resume));
    check_val("exec",       32'(dbg.exec),       32'(m_busy));
    check_val("command",    dbg.command,         m_cmd);
    check_val("data0_in",   dbg.data0_in,        m_d0);
    check_val("data1_in",   dbg.data1_in,        m_d1);
  endtask

  task automatic dmi(input bit we, input logic [6:0] a, input logic [31:0] wd,
                     output logic [31:0] rd);
    @(negedge clk);
    dmi_req = 1; dmi_we = we; dmi_addr = a; dmi_wdata = wd;
    @(negedge clk);
    dmi_req = 0; dmi_we = 0;
    check_val("dmi_ack", 32'(dmi_ack), 32'd1);
    rd = dmi_rdata;
  endtask

  task automatic dmi_write(input logic [6:0] a, input logic [31:0] wd);
    logic [31:0] unused_rd;
    dmi(1'b1, a, wd, unused_rd);
    model_write(a, wd);
    check_outputs();
  endtask

  task automatic dmi_read(input logic [6:0] a, output logic [31:0] rd);
    logic [31:0] exp;
    exp = model_read(a);
    dmi(1'b0, a, 32'h0, rd);
    check_val($sformatf("read_%02h", a), rd, exp);
  endtask

  task automatic core_done(input bit w, input bit b, input bit hr, input bit e,
                           input logic [31:0] d);
    @(negedge clk);
    dbg.done = 1; dbg.write = w; dbg.bus = b; dbg.haltresume = hr; dbg.exception = e;
    dbg.data0_out = d;
    @(negedge clk);
    dbg.done = 0; dbg.write = 0; dbg.bus = 0; dbg.haltresume = 0; dbg.exception = 0;
    model_done(w, b, hr, e, d);
    check_outputs();
  endtask

  task automatic set_halted(input bit v);
    @(negedge clk);
    dbg.halted = v;
    m_halted = v;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [6:0]  addrs [7];
    logic [7:0]  ctypes [7];
    addrs  = '{7'h04, 7'h05, 7'h10, 7'h11, 7'h16, 7'h17, 7'h00};
    ctypes = '{8'd0, 8'd2, 8'd0, 8'd2, 8'd1, 8'd3, 8'hFF};

    rst_n = 0; dmi_req = 0; dmi_we = 0; dmi_addr = 0; dmi_wdata = 0;
    dbg.halted = 0; dbg.done = 0; dbg.write = 0; dbg.bus = 0; dbg.haltresume = 0;
    dbg.exception = 0; dbg.data0_out = 0;
    m_halted = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs();
    check_val("rst_ack",   32'(dmi_ack), 32'd0);
    check_val("rst_rdata", dmi_rdata,    32'd0);
    rst_n = 1;

    // halt request and dmstatus while halted
    dmi_write(ADDR_DMCONTROL, 32'h8000_0001);
    check_val("halt_req_set", 32'(dbg.halt_req), 32'd1);
    set_halted(1);
    dmi_read(ADDR_DMSTATUS, rd);
    check_val("dmstatus_halted", rd, 32'h0000_0382);

    // successful command with data0 writeback
    dmi_write(ADDR_DATA0, 32'h1234);
    dmi_write(ADDR_COMMAND, 32'h0022_1008);
    check_val("exec_on",  32'(dbg.exec), 32'd1);
    check_val("cmd_out",  dbg.command,  32'h0022_1008);
    check_val("d0_in",    dbg.data0_in, 32'h1234);
    core_done(1, 0, 0, 0, 32'hCAFE);
    dmi_read(ADDR_DATA0, rd);
    check_val("data0_wb", rd, 32'hCAFE);
    dmi_read(ADDR_ABSTRACTCS, rd);
    check_val("busy_clr", 32'(rd[12]), 32'd0);

    // busy writes set cmderr=1; W1C clears it
    dmi_write(ADDR_COMMAND, 32'h0022_1008);
    dmi_write(ADDR_DATA1, 32'h5555);
    dmi_read(ADDR_ABSTRACTCS, rd);
    check_val("cmderr_busy", 32'(rd[10:8]), 32'd1);
    dmi_read(ADDR_DATA1, rd);
    check_val("data1_kept", rd, 32'h0);
    dmi_read(ADDR_DATA0, rd);
    dmi_write(ADDR_ABSTRACTCS, 32'h100);
    dmi_read(ADDR_ABSTRACTCS, rd);
    check_val("cmderr_w1c", 32'(rd[10:8]), 32'd0);

    // bus exception wins over write; pending error blocks new commands
    core_done(1, 1, 0, 1, 32'hDEAD);
    dmi_read(ADDR_ABSTRACTCS, rd);
    check_val("cmderr_bus", 32'(rd[10:8]), 32'd5);
    dmi_read(ADDR_DATA0, rd);
    check_val("data0_exc", rd, 32'hCAFE);
    dmi_write(ADDR_COMMAND, 32'h0022_1008);
    check_val("exec_blocked", 32'(dbg.exec), 32'd0);
    dmi_write(ADDR_ABSTRACTCS, 32'h700);

    // resume handshake, then command while running
    dmi_write(ADDR_DMCONTROL, 32'h4000_0001);
    check_val("resume_on", 32'(dbg.resume_req), 32'd1);
    core_done(0, 0, 1, 0, 32'h0);
    check_val("resume_off", 32'(dbg.resume_req), 32'd0);
    set_halted(0);
    dmi_read(ADDR_DMSTATUS, rd);
    check_val("resumeack", 32'(rd[17:16]), 32'd3);
    dmi_write(ADDR_COMMAND, 32'h0022_1008);
    dmi_read(ADDR_ABSTRACTCS, rd);
    check_val("cmderr_running", 32'(rd[10:8]), 32'd4);
    dmi_write(ADDR_ABSTRACTCS, 32'h700);

    // dmactive cleared mid-exec
    set_halted(1);
    dmi_write(ADDR_DATA1, 32'h99);
    dmi_write(ADDR_COMMAND, 32'h0200_0000);
    check_val("exec_mid", 32'(dbg.exec), 32'd1);
    dmi_write(ADDR_DMCONTROL, 32'h0);
    check_val("exec_drop", 32'(dbg.exec), 32'd0);
    dmi_read(ADDR_ABSTRACTCS, rd);
    check_val("abscs_inactive", rd, 32'h2);
    core_done(1, 0, 0, 0, 32'hBEEF);
    dmi_read(ADDR_DATA0, rd);
    check_val("done_ignored", rd, 32'h0);

    // asynchronous reset mid-exec
    dmi_write(ADDR_DMCONTROL, 32'h8000_0001);
    dmi_write(ADDR_DATA0, 32'h77);
    dmi_write(ADDR_COMMAND, 32'h0000_1000);
    check_val("exec_pre_rst", 32'(dbg.exec), 32'd1);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    check_val("arst_exec",     32'(dbg.exec),     32'd0);
    check_val("arst_halt_req", 32'(dbg.halt_req), 32'd0);
    check_val("arst_command",  dbg.command,       32'd0);
    check_val("arst_data0",    dbg.data0_in,      32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1;

    // random traffic
    dmi_write(ADDR_DMCONTROL, 32'h1);
    repeat (400) begin
      case ($urandom_range(0, 7))
        0: dmi_write(ADDR_DMCONTROL, {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                      29'($urandom), 1'($urandom_range(0, 7) != 0)});
        1: dmi_write($urandom_range(0, 1) ? ADDR_DATA0 : ADDR_DATA1, $urandom);
        2: dmi_write(ADDR_COMMAND, {ctypes[$urandom_range(0, 6)], 24'($urandom)});
        3: if ($urandom_range(0, 3) == 0) dmi_write(7'($urandom), $urandom);
           else dmi_write(ADDR_ABSTRACTCS, $urandom);
        4, 5: dmi_read(addrs[$urandom_range(0, 6)], rd);
        6: set_halted(1'($urandom_range(0, 3) != 0));
        default: core_done(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), $urandom);
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
